// File: rtl/matmul_energy_sched.sv
// Sequences one MatMul energy evaluation per candidate sigma. It streams the J
// column chunks from memory, tracks the best (lowest) energy and its sigma, and
// reports accept/reject/abort for every candidate.
module matmul_energy_sched #(
  parameter int unsigned MEM_BANDWIDTH   = 4096,
  parameter int unsigned VECTOR_SIZE     = 256,
  parameter int unsigned J_ELEMENT_WIDTH = 4,
  parameter int unsigned NUM_J_CHUNKS    =
    VECTOR_SIZE / (MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH)),
  parameter int unsigned ENERGY_WIDTH    =
    J_ELEMENT_WIDTH + 2 * $clog2(VECTOR_SIZE) + 1,
  parameter int unsigned ADDR_W          = $clog2(NUM_J_CHUNKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_best,
  input  logic                    cand_valid,
  output logic                    cand_ready,
  input  logic [VECTOR_SIZE-1:0]  cand_sigma,
  output logic                    mm_start,
  output logic [VECTOR_SIZE-1:0]  mm_sigma,
  output logic [ENERGY_WIDTH-1:0] mm_bound,
  output logic                    mm_chunk_valid,
  output logic [ADDR_W-1:0]       mm_chunk_idx,
  input  logic                    mm_early_stop,
  input  logic                    mm_done,
  input  logic [ENERGY_WIDTH-1:0] mm_energy,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ENERGY_WIDTH-1:0] res_energy,
  output logic                    res_accepted,
  output logic                    res_aborted,
  output logic [ENERGY_WIDTH-1:0] best_energy,
  output logic [VECTOR_SIZE-1:0]  best_sigma
);

  // Counters carry one extra bit so they can hold NUM_J_CHUNKS itself.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_J_CHUNKS);
  localparam logic [ENERGY_WIDTH-1:0] E_MAX = {1'b0, {(ENERGY_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_FETCH     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_REPORT    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        req_addr_q, req_addr_d;
  logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;
  logic                    outst_q, outst_d;
  logic                    stop_q, stop_d;
  logic [VECTOR_SIZE-1:0]  mm_sigma_q, mm_sigma_d;
  logic [ENERGY_WIDTH-1:0] best_energy_q, best_energy_d;
  logic [VECTOR_SIZE-1:0]  best_sigma_q, best_sigma_d;
  logic [ENERGY_WIDTH-1:0] res_energy_q, res_energy_d;
  logic                    res_accepted_q, res_accepted_d;
  logic                    res_aborted_q, res_aborted_d;
  logic                    res_valid_q, res_valid_d;
  logic                    cand_ready_q, cand_ready_d;
  logic                    mm_start_q, mm_start_d;
  logic                    mem_req_q, mem_req_d;

  logic gnt_fire;
  logic rx_fire;
  logic chunk_fire;
  logic accept;

  // Handshake qualifiers; a return is only meaningful while a read is in flight.
  always_comb begin
    gnt_fire   = mem_req_q && mem_gnt;
    rx_fire    = (state_q == S_FETCH) && mem_rvalid && outst_q;
    chunk_fire = rx_fire && !stop_q && !mm_early_stop;
    accept     = $signed(mm_energy) < $signed(best_energy_q);
  end

  // Next-state, datapath updates and registered-output precomputation.
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    rx_cnt_d       = rx_cnt_q;
    outst_d        = outst_q;
    stop_d         = stop_q;
    mm_sigma_d     = mm_sigma_q;
    best_energy_d  = best_energy_q;
    best_sigma_d   = best_sigma_q;
    res_energy_d   = res_energy_q;
    res_accepted_d = res_accepted_q;
    res_aborted_d  = res_aborted_q;

    case (state_q)
      S_IDLE: begin
        if (clear_best) begin
          best_energy_d = E_MAX;
        end
        if (cand_valid) begin
          mm_sigma_d = cand_sigma;
          state_d    = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        req_addr_d = '0;
        rx_cnt_d   = '0;
        outst_d    = 1'b0;
        stop_d     = 1'b0;
        state_d    = S_FETCH;
      end

      S_FETCH: begin
        if (gnt_fire) begin
          req_addr_d = req_addr_q + CNT_W'(1);
        end
        outst_d = (outst_q && !rx_fire) || gnt_fire;
        if (chunk_fire) begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
        if (mm_early_stop) begin
          stop_d = 1'b1;
        end
        // An aborted evaluation waits for its in-flight read to drain.
        if (stop_d && !outst_d) begin
          res_energy_d   = best_energy_q;
          res_accepted_d = 1'b0;
          res_aborted_d  = 1'b1;
          state_d        = S_REPORT;
        end else if (!stop_d && (rx_cnt_d == LAST_CNT)) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (mm_done) begin
          res_energy_d   = mm_energy;
          res_accepted_d = accept;
          res_aborted_d  = 1'b0;
          if (accept) begin
            best_energy_d = mm_energy;
            best_sigma_d  = mm_sigma_q;
          end
          state_d = S_REPORT;
        end else if (mm_early_stop) begin
          res_energy_d   = best_energy_q;
          res_accepted_d = 1'b0;
          res_aborted_d  = 1'b1;
          state_d        = S_REPORT;
        end
      end

      S_REPORT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cand_ready_d = (state_d == S_IDLE);
    mm_start_d   = (state_d == S_LAUNCH);
    res_valid_d  = (state_d == S_REPORT);
    mem_req_d    = (state_d == S_FETCH) && !outst_d && !stop_d &&
                   (req_addr_d < LAST_CNT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_addr_q     <= '0;
      rx_cnt_q       <= '0;
      outst_q        <= 1'b0;
      stop_q         <= 1'b0;
      mm_sigma_q     <= '0;
      best_energy_q  <= E_MAX;
      best_sigma_q   <= '0;
      res_energy_q   <= '0;
      res_accepted_q <= 1'b0;
      res_aborted_q  <= 1'b0;
      res_valid_q    <= 1'b0;
      cand_ready_q   <= 1'b1;
      mm_start_q     <= 1'b0;
      mem_req_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      rx_cnt_q       <= rx_cnt_d;
      outst_q        <= outst_d;
      stop_q         <= stop_d;
      mm_sigma_q     <= mm_sigma_d;
      best_energy_q  <= best_energy_d;
      best_sigma_q   <= best_sigma_d;
      res_energy_q   <= res_energy_d;
      res_accepted_q <= res_accepted_d;
      res_aborted_q  <= res_aborted_d;
      res_valid_q    <= res_valid_d;
      cand_ready_q   <= cand_ready_d;
      mm_start_q     <= mm_start_d;
      mem_req_q      <= mem_req_d;
    end
  end

  // Chunk valid follows the memory return in the same cycle.
  always_comb begin
    mm_chunk_valid = chunk_fire;
    mm_chunk_idx   = rx_cnt_q[ADDR_W-1:0];
  end

  assign cand_ready   = cand_ready_q;
  assign mm_start     = mm_start_q;
  assign mm_sigma     = mm_sigma_q;
  assign mm_bound     = best_energy_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = req_addr_q[ADDR_W-1:0];
  assign res_valid    = res_valid_q;
  assign res_energy   = res_energy_q;
  assign res_accepted = res_accepted_q;
  assign res_aborted  = res_aborted_q;
  assign best_energy  = best_energy_q;
  assign best_sigma   = best_sigma_q;

endmodule

// File: tb/tb_matmul_energy_sched.sv
// Directed bench for matmul_energy_sched with a small J-memory responder.
module tb_matmul_energy_sched;

  localparam int unsigned VS  = 256;
  localparam int unsigned EW  = 21;
  localparam int unsigned AW  = 6;
  localparam int          NCH = 64;
  localparam logic [EW-1:0] E_MAX = 21'h0F_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_best;
  logic          cand_valid;
  logic          cand_ready;
  logic [VS-1:0] cand_sigma;
  logic          mm_start;
  logic [VS-1:0] mm_sigma;
  logic [EW-1:0] mm_bound;
  logic          mm_chunk_valid;
  logic [AW-1:0] mm_chunk_idx;
  logic          mm_early_stop;
  logic          mm_done;
  logic [EW-1:0] mm_energy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic          res_valid;
  logic          res_ready;
  logic [EW-1:0] res_energy;
  logic          res_accepted;
  logic          res_aborted;
  logic [EW-1:0] best_energy;
  logic [VS-1:0] best_sigma;

  always #5 clk = ~clk;

  matmul_energy_sched dut (
    .clk(clk), .rst(rst), .clear_best(clear_best),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_sigma(cand_sigma),
    .mm_start(mm_start), .mm_sigma(mm_sigma), .mm_bound(mm_bound),
    .mm_chunk_valid(mm_chunk_valid), .mm_chunk_idx(mm_chunk_idx),
    .mm_early_stop(mm_early_stop), .mm_done(mm_done), .mm_energy(mm_energy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .res_valid(res_valid), .res_ready(res_ready),
    .res_energy(res_energy), .res_accepted(res_accepted),
    .res_aborted(res_aborted), .best_energy(best_energy),
    .best_sigma(best_sigma)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [VS-1:0] obs,
                          input logic [VS-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] en(input int v);
    return EW'(v);
  endfunction

  // Memory responder and monitor state
  bit rand_mode = 1'b0;
  int fix_lat   = 0;
  bit pend      = 1'b0;
  int lat_cnt   = 0;
  int stall_cnt = 0;
  bit stopped   = 1'b0;
  int addr_q[$];
  int idx_q[$];
  int two_out        = 0;
  int req_after_stop = 0;
  int start_n        = 0;

  // Drive gnt/rvalid mid-cycle, then sample the DUT's reaction
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        mem_rvalid = 1'b1;
        pend = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (pend) two_out++;
      if (stall_cnt == 0) begin
        mem_gnt   = 1'b1;
        pend      = 1'b1;
        lat_cnt   = rand_mode ? int'($urandom_range(0, 5)) : fix_lat;
        stall_cnt = rand_mode ? int'($urandom_range(0, 5)) : 0;
      end else begin
        stall_cnt--;
      end
    end
    #1;
    if (mem_req && mem_gnt) addr_q.push_back(int'(mem_addr));
    if (mm_chunk_valid) idx_q.push_back(int'(mm_chunk_idx));
    if (mem_req && stopped) req_after_stop++;
    if (mm_start) start_n++;
  end

  task automatic clear_mon();
    addr_q.delete();
    idx_q.delete();
    start_n = 0;
  endtask

  task automatic launch(input logic [VS-1:0] sig);
    int t;
    t = 0;
    @(negedge clk);
    while (!cand_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("cand_ready_before_launch", cand_ready, 1'b1);
    cand_valid = 1'b1;
    cand_sigma = sig;
    @(negedge clk);
    cand_valid = 1'b0;
  endtask

  task automatic wait_chunks(input int n);
    int t;
    t = 0;
    while (idx_q.size() < n && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check_eq("chunks_reached", idx_q.size() >= n, 1'b1);
  endtask

  task automatic send_done(input logic [EW-1:0] e);
    @(negedge clk);
    mm_energy = e;
    mm_done   = 1'b1;
    @(negedge clk);
    mm_done   = 1'b0;
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    while (!res_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("res_valid_seen", res_valid, 1'b1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("cand_ready_after_release", cand_ready, 1'b1);
    check_eq("res_valid_after_release", res_valid, 1'b0);
  endtask

  task automatic check_seq(input int n_addr, input int n_idx);
    int bad;
    bad = (addr_q.size() != n_addr) ? 1 : 0;
    foreach (addr_q[i]) if (addr_q[i] != i) bad++;
    check_eq("addr_seq", bad, 0);
    bad = (idx_q.size() != n_idx) ? 1 : 0;
    foreach (idx_q[i]) if (idx_q[i] != i) bad++;
    check_eq("idx_seq", bad, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [VS-1:0] s_a, s_b, s_c, s_d, s_e, s_f, s_g, s_h, s_i;
    logic [EW-1:0] r_e;
    logic          r_acc, r_ab;
    int            unstable;
    int            nchunk;
    int            t;

    s_a = {8{32'hA5A5_0001}};
    s_b = {8{32'h0F0F_1234}};
    s_c = {8{32'hDEAD_BEEF}};
    s_d = {8{32'h1357_9BDF}};
    s_e = {8{32'h2468_ACE0}};
    s_f = {8{32'hCAFE_F00D}};
    s_g = {8{32'h0000_FFFF}};
    s_h = {8{32'h7777_1111}};
    s_i = {8{32'h8001_8001}};

    rst = 1'b1; clear_best = 1'b0; cand_valid = 1'b0; cand_sigma = '0;
    mm_early_stop = 1'b0; mm_done = 1'b0; mm_energy = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_cand_ready", cand_ready, 1'b1);
    check_eq("rst_best_energy", best_energy, E_MAX);
    check_eq("rst_best_sigma", best_sigma, '0);
    check_eq("rst_mm_sigma", mm_sigma, '0);
    check_eq("rst_outputs", {mem_req, mm_start, res_valid, res_accepted, res_aborted}, 5'b0);

    // Candidate A: full evaluation, accepted
    clear_mon();
    launch(s_a);
    wait_chunks(NCH);
    send_done(en(-1000));
    wait_res();
    check_eq("a_accepted", res_accepted, 1'b1);
    check_eq("a_aborted", res_aborted, 1'b0);
    check_eq("a_energy", res_energy, en(-1000));
    check_eq("a_best_energy", best_energy, en(-1000));
    check_eq("a_best_sigma", best_sigma, s_a);
    check_eq("a_mm_bound", mm_bound, en(-1000));
    check_eq("a_start_pulses", start_n, 1);
    check_seq(NCH, NCH);
    release_res();

    // Candidate B: tie rejects
    clear_mon();
    launch(s_b);
    wait_chunks(NCH);
    send_done(en(-1000));
    wait_res();
    check_eq("b_accepted", res_accepted, 1'b0);
    check_eq("b_energy", res_energy, en(-1000));
    check_eq("b_best_sigma", best_sigma, s_a);
    release_res();

    // Candidate C: one lower wins
    clear_mon();
    launch(s_c);
    wait_chunks(NCH);
    send_done(en(-1001));
    wait_res();
    check_eq("c_accepted", res_accepted, 1'b1);
    check_eq("c_best_energy", best_energy, en(-1001));
    check_eq("c_best_sigma", best_sigma, s_c);
    release_res();

    // Candidate D: early stop after chunk 10 with a read in flight
    clear_mon();
    fix_lat = 3;
    launch(s_d);
    t = 0;
    while (!(idx_q.size() >= 11 && pend) && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check_eq("d_stop_point_reached", (idx_q.size() == 11) && pend, 1'b1);
    mm_early_stop = 1'b1;
    stopped = 1'b1;
    @(negedge clk);
    mm_early_stop = 1'b0;
    wait_res();
    check_eq("d_aborted", res_aborted, 1'b1);
    check_eq("d_accepted", res_accepted, 1'b0);
    check_eq("d_energy", res_energy, en(-1001));
    check_eq("d_best_energy", best_energy, en(-1001));
    check_eq("d_best_sigma", best_sigma, s_c);
    check_eq("d_read_drained", pend, 1'b0);
    check_eq("d_req_after_stop", req_after_stop, 0);
    check_seq(12, 11);
    release_res();
    stopped = 1'b0;
    fix_lat = 0;

    // Candidate E: random memory stalls, rejected
    clear_mon();
    rand_mode = 1'b1;
    two_out = 0;
    launch(s_e);
    wait_chunks(NCH);
    send_done(en(5));
    wait_res();
    check_eq("e_accepted", res_accepted, 1'b0);
    check_eq("e_energy", res_energy, en(5));
    check_eq("e_best_energy", best_energy, en(-1001));
    check_eq("e_two_outstanding", two_out, 0);
    check_seq(NCH, NCH);
    release_res();
    rand_mode = 1'b0;

    // Candidate F: result held 20 cycles while a new candidate knocks
    clear_mon();
    launch(s_f);
    wait_chunks(NCH);
    send_done(en(-2000));
    wait_res();
    r_e = res_energy; r_acc = res_accepted; r_ab = res_aborted;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      cand_valid = 1'b1;
      cand_sigma = ~s_f;
      @(negedge clk);
      if (res_energy !== r_e || res_accepted !== r_acc || res_aborted !== r_ab ||
          res_valid !== 1'b1 || cand_ready !== 1'b0) unstable++;
    end
    check_eq("f_hold_stable", unstable, 0);
    check_eq("f_accepted", r_acc, 1'b1);
    check_eq("f_energy", r_e, en(-2000));
    cand_valid = 1'b0;
    release_res();
    check_eq("f_sigma_not_retaken", mm_sigma, s_f);
    check_eq("f_start_pulses", start_n, 1);
    check_eq("f_best_sigma", best_sigma, s_f);

    // clear_best alone in IDLE keeps best_sigma
    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    @(negedge clk);
    check_eq("clr_best_energy", best_energy, E_MAX);
    check_eq("clr_best_sigma", best_sigma, s_f);
    check_eq("clr_still_idle", cand_ready, 1'b1);

    // Candidate H accepted against the cleared bound
    clear_mon();
    launch(s_h);
    wait_chunks(NCH);
    send_done(en(-50));
    wait_res();
    check_eq("h_accepted", res_accepted, 1'b1);
    check_eq("h_best_energy", best_energy, en(-50));
    release_res();

    // Candidate G: reset in mid-fetch
    clear_mon();
    launch(s_g);
    wait_chunks(30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst2_best_energy", best_energy, E_MAX);
    check_eq("rst2_best_sigma", best_sigma, '0);
    check_eq("rst2_mm_sigma", mm_sigma, '0);
    check_eq("rst2_flags", {cand_ready, mem_req, res_valid, mm_start}, 4'b1000);
    nchunk = idx_q.size();
    repeat (3) @(negedge clk);
    check_eq("rst2_late_rvalid_ignored", idx_q.size(), nchunk);
    check_eq("rst2_idle_no_req", mem_req, 1'b0);

    // clear_best together with cand_valid: clear and take candidate
    clear_best = 1'b1;
    cand_valid = 1'b1;
    cand_sigma = s_i;
    @(negedge clk);
    clear_best = 1'b0;
    cand_valid = 1'b0;
    check_eq("i_mm_sigma", mm_sigma, s_i);
    check_eq("i_best_energy", best_energy, E_MAX);
    check_eq("i_cand_ready", cand_ready, 1'b0);
    check_eq("i_mm_start", mm_start, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_energy_sched.md
Name: matmul_energy_sched

Overview:
Scheduler that sequences one MatMul energy evaluation (E = sigma^T J sigma) per candidate spin vector. It accepts candidates from the annealing front-end and starts MatMul. It streams the NUM_J_CHUNKS column-chunk reads of J from the J memory to MatMul, then collects the energy. It keeps the best (lowest) energy and sigma seen so far and reports accept/reject per candidate. It sits between the sigma proposal logic, the J SRAM read port and the MatMul datapath.

Parameters:
MEM_BANDWIDTH, 4096, J memory read width in bits
VECTOR_SIZE, 256, spins per sigma
J_ELEMENT_WIDTH, 4, bits per unsigned J element
NUM_J_CHUNKS, VECTOR_SIZE/(MEM_BANDWIDTH/(VECTOR_SIZE*J_ELEMENT_WIDTH)) = 64, reads per evaluation
ENERGY_WIDTH, J_ELEMENT_WIDTH+2*$clog2(VECTOR_SIZE)+1 = 21, signed energy width
ADDR_W, $clog2(NUM_J_CHUNKS) = 6, chunk address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear_best  in  1  pulse: reload best_energy with max positive; IDLE only, ignored otherwise
cand_valid  in  1  candidate sigma valid
cand_ready  out  1  scheduler can accept a candidate
cand_sigma  in  VECTOR_SIZE  candidate spins, 1=+1, 0=-1
mm_start  out  1  one-cycle start pulse to MatMul
mm_sigma  out  VECTOR_SIZE  latched candidate sigma, stable for the whole evaluation
mm_bound  out  ENERGY_WIDTH  Energy_previous for MatMul; equals best_energy
mm_chunk_valid  out  1  J chunk on memory data bus is valid for MatMul this cycle
mm_chunk_idx  out  ADDR_W  column-chunk index of the current valid chunk
mm_early_stop  in  1  MatMul partial energy already exceeds bound
mm_done  in  1  MatMul final energy valid (one-cycle pulse)
mm_energy  in  ENERGY_WIDTH  signed final energy
mem_req  out  1  J read request
mem_addr  out  ADDR_W  chunk address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data returned; in-order, at most one outstanding
res_valid  out  1  result valid
res_ready  in  1  consumer takes result
res_energy  out  ENERGY_WIDTH  energy of the evaluated candidate (bound value if early-stopped)
res_accepted  out  1  candidate became new best
res_aborted  out  1  evaluation ended by early stop
best_energy  out  ENERGY_WIDTH  signed best energy
best_sigma  out  VECTOR_SIZE  sigma of best energy

Behaviour:
- Reset values: state IDLE. cand_ready=1. All pulses, res_*, mem_req, mem_addr and chunk counters are 0. best_energy = {1'b0,{ENERGY_WIDTH-1{1'b1}}} (2^20-1). best_sigma=0. mm_sigma=0. Reset mid-evaluation abandons it; any late mem_rvalid or mm_done after reset is ignored in IDLE.
- States: IDLE -> LAUNCH -> FETCH -> WAIT_DONE -> REPORT -> IDLE.
- IDLE: cand_ready=1. On cand_valid, latch cand_sigma into mm_sigma and go to LAUNCH. cand_ready is 0 in all other states. clear_best in IDLE reloads best_energy only; best_sigma is kept. If clear_best and cand_valid arrive together, the clear applies first and the candidate is taken.
- LAUNCH (1 cycle): mm_start=1, req_addr=0, rx_cnt=0. Next state FETCH.
- FETCH: mem_req=1 while req_addr<NUM_J_CHUNKS and no read is outstanding. On mem_gnt, req_addr increments and the outstanding flag is set. On mem_rvalid: mm_chunk_valid=1 in the same cycle (combinational), mm_chunk_idx=rx_cnt, rx_cnt increments, outstanding flag clears. A gnt and rvalid in the same cycle are legal: the flag stays set. When rx_cnt reaches NUM_J_CHUNKS, go to WAIT_DONE. Minimum FETCH length is 2*NUM_J_CHUNKS cycles with 1-cycle read latency.
- Early stop: mm_early_stop in FETCH or WAIT_DONE stops new requests. If a read is outstanding, its rvalid is absorbed without asserting mm_chunk_valid. Then go to REPORT with res_aborted=1, res_accepted=0, res_energy=mm_bound. An mm_done in the same cycle as mm_early_stop wins: normal compare.
- WAIT_DONE: wait for mm_done. Compare signed: accept iff $signed(mm_energy) < $signed(best_energy); ties reject. On accept, best_energy/best_sigma update in the cycle after mm_done, together with REPORT entry. mm_bound changes only there.
- REPORT: res_valid=1 and res_* held stable until res_ready. Leave to IDLE in the cycle res_ready=1. cand_ready rises the following cycle.
- Arithmetic: the only arithmetic is the signed compare and the counters. rx_cnt and req_addr are ADDR_W+1 bits so they reach NUM_J_CHUNKS without wrap.

Test Plan:
- Reset, then single candidate, mm_energy=-1000, 1-cycle memory -> 64 mem_req grants with addr 0..63 in order, 64 mm_chunk_valid pulses idx 0..63, res_accepted=1, best_energy=-1000.
- Second candidate with mm_energy=-1000, then a third with -1001 -> second: res_accepted=0 (tie), best unchanged; third: accepted, best_sigma equals the third sigma.
- mm_early_stop asserted after chunk 10 with one read outstanding -> no further mem_req, outstanding rvalid gives no mm_chunk_valid, res_aborted=1, res_energy=best_energy, best unchanged.
- Memory with random gnt/rvalid stalls (0-5 cycles) -> chunk indices still 0..63 contiguous, never two reads outstanding.
- res_ready held low 20 cycles -> res_* stable, cand_ready=0 throughout, new cand_valid not taken.
- rst asserted in mid-FETCH at chunk 30, plus clear_best together with cand_valid in IDLE -> outputs return to reset values next cycle. best_energy reads 2^20-1 and the candidate is latched.
